// File: rtl/gic_slave_pkg.sv
// Shared GIC link definitions: line nibbles, ack codes, command bit positions,
// checksum operand, slave FSM states and the stored-response record.
package gic_slave_pkg;

  // Line nibbles
  localparam logic [3:0] GIC_MST_INIT = 4'b1010;
  localparam logic [3:0] GIC_SLV_INIT = 4'b0101;
  localparam logic [3:0] GIC_IDLE     = 4'b1111;

  // Operand XORed into the checksum on the last nibble of each field
  localparam logic [3:0] GIC_CKS_OP   = 4'b1100;

  // Ack codes returned in the ack nibble {ack, 2'b00}
  localparam logic [1:0] ACK_OK  = 2'b00;
  localparam logic [1:0] ACK_CKS = 2'b01;
  localparam logic [1:0] ACK_ERR = 2'b10;
  localparam logic [1:0] ACK_RTY = 2'b11;

  // Command nibble bit positions (bit 0 is ignored)
  localparam int CMD_W_BIT   = 3;
  localparam int CMD_IRQ_BIT = 2;
  localparam int CMD_RTY_BIT = 1;

  // Wishbone wait cycles before an access is aborted with ERR
  localparam logic [7:0] WB_TIMEOUT = 8'd255;

  typedef enum logic [3:0] {
    RX_IDLE,
    RX_CMD,
    RX_SEL,
    RX_ADR,
    RX_DAT,
    RX_CKS,
    WB,
    TX_WAIT,
    TX_INIT,
    TX_ACK,
    TX_DAT,
    TX_CKS,
    TX_DONE
  } gic_state_t;

  // Response kept for transmission and for later replay on an RTY command.
  // has_dat is set when the originating frame was a read, so the data
  // nibbles and checksum follow the ack nibble.
  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] dat;
    logic [3:0]  cks;
    logic        has_dat;
  } gic_rsp_t;

  localparam gic_rsp_t RSP_RESET = '{ack: ACK_OK, dat: 32'h0, cks: GIC_CKS_OP, has_dat: 1'b0};

  // Response checksum: XOR of all data nibbles, plus the operand on nibble 0
  function automatic logic [3:0] gic_rsp_cksum(input logic [31:0] dat);
    logic [3:0] c;
    c = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      c = c ^ dat[i*4 +: 4];
    end
    return c ^ GIC_CKS_OP;
  endfunction

endpackage

// File: rtl/gic_cksum.sv
// Running 4-bit GIC checksum: clear, load a seed, or accumulate one nibble.
// The last nibble of a field additionally gets the checksum operand.
module gic_cksum
  import gic_slave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       acc,
  input  logic [3:0] nib,
  input  logic       last,
  output logic [3:0] cks
);

  logic [3:0] cks_q, cks_d;

  // Next checksum value: clear has priority over load, load over accumulate
  always_comb begin
    cks_d = cks_q;
    if (clr) begin
      cks_d = 4'h0;
    end else if (load) begin
      cks_d = load_val;
    end else if (acc) begin
      cks_d = cks_q ^ nib ^ (last ? GIC_CKS_OP : 4'h0);
    end
  end

  // Checksum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_q <= 4'h0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign cks = cks_q;

endmodule

// File: rtl/gic_slave.sv
// GIC link slave: receives a command frame nibble by nibble, checks its
// checksum, runs one Wishbone access (or answers an IRQ query / replays the
// previous response) and sends the response frame back over the shared bus.
//
// Wishbone handshake: cyc/stb act as valid and stay high with adr/sel/we/dat
// stable until the slave terminates the access with ack, err or rty (the
// ready side); the terminating cycle is the last one with cyc/stb high.
module gic_slave
  import gic_slave_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [3:0]  gic_dat_i,
  input  logic        gic_cs_i,
  output logic [3:0]  gic_dat_o,
  output logic        gic_oe_o,
  input  logic [31:0] irq_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  gic_state_t  state_q, state_d;
  logic [3:1]  cmd_q, cmd_d;
  logic [2:0]  nib_cnt_q, nib_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  gic_rsp_t    rsp_q, rsp_d;
  logic [3:0]  dat_o_q, dat_o_d;
  logic        drive_q, drive_d;

  logic        ck_clr, ck_load, ck_acc, ck_last;
  logic [3:0]  rx_cks;
  logic        wb_done;
  logic [1:0]  wb_code;
  logic [31:0] wb_rdata;

  // Receive checksum over sel, address and write data
  gic_cksum u_rx_cksum (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .clr      (ck_clr),
    .load     (ck_load),
    .load_val (gic_dat_i),
    .acc      (ck_acc),
    .nib      (gic_dat_i),
    .last     (ck_last),
    .cks      (rx_cks)
  );

  // Next-state, datapath and registered-output logic of the frame FSM
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    nib_cnt_d  = nib_cnt_q;
    wait_cnt_d = wait_cnt_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    rsp_d      = rsp_q;
    dat_o_d    = GIC_IDLE;
    ck_clr     = 1'b0;
    ck_load    = 1'b0;
    ck_acc     = 1'b0;
    ck_last    = (nib_cnt_q == 3'd0);
    wb_done    = 1'b0;
    wb_code    = ACK_OK;
    wb_rdata   = 32'h0;

    case (state_q)
      RX_IDLE: begin
        ck_clr = 1'b1;
        if (!gic_cs_i && gic_dat_i == GIC_MST_INIT) begin
          state_d = RX_CMD;
        end
      end

      RX_CMD: begin
        cmd_d = gic_dat_i[3:1];
        // A retry command skips the rest of the frame and resends the
        // stored response untouched.
        state_d = gic_dat_i[CMD_RTY_BIT] ? TX_WAIT : RX_SEL;
      end

      RX_SEL: begin
        sel_d     = gic_dat_i;
        ck_load   = 1'b1;
        nib_cnt_d = 3'd7;
        state_d   = RX_ADR;
      end

      RX_ADR: begin
        adr_d  = {adr_q[27:0], gic_dat_i};
        ck_acc = 1'b1;
        if (nib_cnt_q == 3'd0) begin
          nib_cnt_d = 3'd7;
          state_d   = cmd_q[CMD_W_BIT] ? RX_DAT : RX_CKS;
        end else begin
          nib_cnt_d = nib_cnt_q - 3'd1;
        end
      end

      RX_DAT: begin
        wdat_d = {wdat_q[27:0], gic_dat_i};
        ck_acc = 1'b1;
        if (nib_cnt_q == 3'd0) begin
          state_d = RX_CKS;
        end else begin
          nib_cnt_d = nib_cnt_q - 3'd1;
        end
      end

      RX_CKS: begin
        if (gic_dat_i != rx_cks) begin
          rsp_d.ack     = ACK_CKS;
          rsp_d.dat     = 32'h0;
          rsp_d.cks     = gic_rsp_cksum(32'h0);
          rsp_d.has_dat = ~cmd_q[CMD_W_BIT];
          state_d       = TX_WAIT;
        end else if (cmd_q[CMD_IRQ_BIT]) begin
          rsp_d.ack     = ACK_OK;
          rsp_d.dat     = irq_i;
          rsp_d.cks     = gic_rsp_cksum(irq_i);
          rsp_d.has_dat = ~cmd_q[CMD_W_BIT];
          state_d       = TX_WAIT;
        end else begin
          cyc_d      = 1'b1;
          we_d       = cmd_q[CMD_W_BIT];
          wait_cnt_d = 8'd0;
          state_d    = WB;
        end
      end

      WB: begin
        // ack beats err beats rty; no response within the wait budget is
        // reported as an error
        wb_done = 1'b1;
        if (wbm_ack_i) begin
          wb_code  = ACK_OK;
          wb_rdata = cmd_q[CMD_W_BIT] ? 32'h0 : wbm_dat_i;
        end else if (wbm_err_i) begin
          wb_code = ACK_ERR;
        end else if (wbm_rty_i) begin
          wb_code = ACK_RTY;
        end else if (wait_cnt_q == WB_TIMEOUT - 8'd1) begin
          wb_code = ACK_ERR;
        end else begin
          wb_done    = 1'b0;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (wb_done) begin
          cyc_d         = 1'b0;
          we_d          = 1'b0;
          rsp_d.ack     = wb_code;
          rsp_d.dat     = wb_rdata;
          rsp_d.cks     = gic_rsp_cksum(wb_rdata);
          rsp_d.has_dat = ~cmd_q[CMD_W_BIT];
          state_d       = TX_WAIT;
        end
      end

      TX_WAIT: begin
        if (gic_cs_i) begin
          state_d = TX_INIT;
          dat_o_d = GIC_SLV_INIT;
        end
      end

      TX_INIT: begin
        if (!gic_cs_i) begin
          state_d = RX_IDLE;
        end else begin
          state_d = TX_ACK;
          dat_o_d = {rsp_q.ack, 2'b00};
        end
      end

      TX_ACK: begin
        if (!gic_cs_i) begin
          state_d = RX_IDLE;
        end else if (rsp_q.has_dat) begin
          state_d   = TX_DAT;
          nib_cnt_d = 3'd7;
          dat_o_d   = rsp_q.dat[31:28];
        end else begin
          state_d = TX_DONE;
        end
      end

      TX_DAT: begin
        if (!gic_cs_i) begin
          state_d = RX_IDLE;
        end else if (nib_cnt_q == 3'd0) begin
          state_d = TX_CKS;
          dat_o_d = rsp_q.cks;
        end else begin
          nib_cnt_d = nib_cnt_q - 3'd1;
          dat_o_d   = rsp_q.dat[{nib_cnt_d, 2'b00} +: 4];
        end
      end

      TX_CKS: begin
        state_d = gic_cs_i ? TX_DONE : RX_IDLE;
      end

      TX_DONE: begin
        if (!gic_cs_i) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase

    drive_d = state_d inside {TX_WAIT, TX_INIT, TX_ACK, TX_DAT, TX_CKS, TX_DONE};
  end

  // State, datapath and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= RX_IDLE;
      cmd_q      <= 3'h0;
      nib_cnt_q  <= 3'd0;
      wait_cnt_q <= 8'd0;
      adr_q      <= 32'h0;
      wdat_q     <= 32'h0;
      sel_q      <= 4'h0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      rsp_q      <= RSP_RESET;
      dat_o_q    <= GIC_IDLE;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      nib_cnt_q  <= nib_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      rsp_q      <= rsp_d;
      dat_o_q    <= dat_o_d;
      drive_q    <= drive_d;
    end
  end

  assign gic_dat_o = dat_o_q;
  assign gic_oe_o  = gic_cs_i & drive_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;

endmodule

// File: tb/tb_gic_slave.sv
// Bench for gic_slave: a master-side frame driver, a behavioural Wishbone
// slave and a response model that derives every expected line nibble from
// the link rules (checksums by XOR over fields, stored-response replay).
module tb_gic_slave;

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic [3:0]  gic_dat_i;
  logic        gic_cs_i;
  logic [3:0]  gic_dat_o;
  logic        gic_oe_o;
  logic [31:0] irq_i;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of expected line nibbles for the current response
  logic [3:0] exp_q[$];

  // Reference model of the stored response
  logic [1:0]  m_ack;
  logic [31:0] m_dat;
  logic        m_has;

  // Wishbone slave behaviour and observations
  int          wb_mode = 0;   // 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err+rty, 5 err+rty
  int          wb_lat  = 0;
  logic [31:0] wb_rdata = 32'h0;
  int          wb_starts = 0;
  int          wb_cyc_total = 0;
  int          wb_busy = 0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we, cap_stb;

  gic_slave dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .gic_dat_i (gic_dat_i),
    .gic_cs_i  (gic_cs_i),
    .gic_dat_o (gic_dat_o),
    .gic_oe_o  (gic_oe_o),
    .irq_i     (irq_i),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_bte_o (wbm_bte_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_rty_i (wbm_rty_i)
  );

  // Clock
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // Wishbone slave: answers after wb_lat cycles according to wb_mode
  initial begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(negedge wb_clk_i);
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_rty_i = 1'b0;
      wbm_dat_i = $urandom();
      if (wbm_cyc_o) begin
        if (wb_busy == 0) begin
          wb_starts++;
          cap_adr = wbm_adr_o;
          cap_dat = wbm_dat_o;
          cap_sel = wbm_sel_o;
          cap_we  = wbm_we_o;
          cap_stb = wbm_stb_o;
        end
        wb_cyc_total++;
        if (wb_busy == wb_lat) begin
          wbm_dat_i = wb_rdata;
          case (wb_mode)
            0: wbm_ack_i = 1'b1;
            1: wbm_err_i = 1'b1;
            2: wbm_rty_i = 1'b1;
            4: begin wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_rty_i = 1'b1; end
            5: begin wbm_err_i = 1'b1; wbm_rty_i = 1'b1; end
            default: ;
          endcase
        end
        wb_busy++;
      end else begin
        wb_busy = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Receive checksum from the link rules: sel, then every field nibble,
  // with the operand folded in once per field for its nibble 0.
  function automatic logic [3:0] rx_cks(input logic [3:0] sel, input logic [31:0] adr,
                                        input logic [31:0] dat, input logic w);
    logic [3:0] c;
    c = sel;
    for (int i = 0; i < 8; i++) c = c ^ adr[i*4 +: 4];
    c = c ^ 4'b1100;
    if (w) begin
      for (int i = 0; i < 8; i++) c = c ^ dat[i*4 +: 4];
      c = c ^ 4'b1100;
    end
    return c;
  endfunction

  function automatic logic [3:0] rsp_cks(input logic [31:0] dat);
    logic [3:0] c;
    c = 4'b1100;
    for (int i = 0; i < 8; i++) c = c ^ dat[i*4 +: 4];
    return c;
  endfunction

  function automatic logic [1:0] mode_ack(input int mode);
    case (mode)
      0, 4:    return 2'b00;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic send_nib(input logic [3:0] n);
    @(negedge wb_clk_i);
    gic_dat_i = n;
  endtask

  // Drive a complete command frame as the master would
  task automatic send_req(input logic [3:0] cmd, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [3:0] cks);
    send_nib(4'b1010);
    send_nib(cmd);
    if (!cmd[1]) begin
      send_nib(sel);
      for (int i = 7; i >= 0; i--) send_nib(adr[i*4 +: 4]);
      if (cmd[3]) for (int i = 7; i >= 0; i--) send_nib(wdat[i*4 +: 4]);
      send_nib(cks);
    end
    @(negedge wb_clk_i);
    gic_dat_i = 4'hF;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " dat_o"}, {28'h0, gic_dat_o}, 32'hF);
    chk({tag, " oe"}, {31'h0, gic_oe_o}, 32'h0);
    chk({tag, " cyc"}, {31'h0, wbm_cyc_o}, 32'h0);
    chk({tag, " stb"}, {31'h0, wbm_stb_o}, 32'h0);
    chk({tag, " we"}, {31'h0, wbm_we_o}, 32'h0);
    chk({tag, " adr"}, wbm_adr_o, 32'h0);
    chk({tag, " wdat"}, wbm_dat_o, 32'h0);
    chk({tag, " sel"}, {28'h0, wbm_sel_o}, 32'h0);
  endtask

  // One full transaction: model the response, drive the frame, hand the bus
  // over and compare every response nibble plus the Wishbone activity.
  task automatic run_frame(input string name, input logic [3:0] cmd, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] cks_flip);
    logic       w, irq, rty, found;
    logic [3:0] e;
    int         exp_starts, exp_cyc;
    w = cmd[3]; irq = cmd[2]; rty = cmd[1];
    exp_starts = 0;
    exp_cyc = 0;
    if (!rty) begin
      m_has = !w;
      if (cks_flip != 4'h0) begin
        m_ack = 2'b01; m_dat = 32'h0;
      end else if (irq) begin
        m_ack = 2'b00; m_dat = irq_i;
      end else begin
        exp_starts = 1;
        exp_cyc = (wb_mode == 3) ? 255 : wb_lat + 1;
        m_ack = mode_ack(wb_mode);
        m_dat = (m_ack == 2'b00 && !w) ? wb_rdata : 32'h0;
      end
    end
    exp_q.delete();
    exp_q.push_back(4'b0101);
    exp_q.push_back({m_ack, 2'b00});
    if (m_has) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(m_dat[i*4 +: 4]);
      exp_q.push_back(rsp_cks(m_dat));
    end
    wb_starts = 0;
    wb_cyc_total = 0;
    send_req(cmd, sel, adr, wdat, rx_cks(sel, adr, wdat, w) ^ cks_flip);
    gic_cs_i = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      if (gic_oe_o && gic_dat_o == 4'b0101) found = 1'b1;
      else @(negedge wb_clk_i);
    end
    chk({name, " tx_start"}, {31'h0, found}, 32'h1);
    if (found) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({name, " tx_nib"}, {28'h0, gic_dat_o}, {28'h0, e});
        @(negedge wb_clk_i);
      end
      chk({name, " tx_done_idle"}, {27'h0, gic_oe_o, gic_dat_o}, 32'h1F);
    end
    exp_q.delete();
    gic_cs_i = 1'b0;
    #1;
    chk({name, " oe_release"}, {31'h0, gic_oe_o}, 32'h0);
    chk({name, " wb_starts"}, wb_starts, exp_starts);
    if (exp_starts != 0) begin
      chk({name, " wb_cycles"}, wb_cyc_total, exp_cyc);
      chk({name, " wb_adr"}, cap_adr, adr);
      chk({name, " wb_sel"}, {28'h0, cap_sel}, {28'h0, sel});
      chk({name, " wb_we"}, {31'h0, cap_we}, {31'h0, w});
      chk({name, " wb_stb"}, {31'h0, cap_stb}, 32'h1);
      if (w) chk({name, " wb_wdat"}, cap_dat, wdat);
    end
  endtask

  initial begin
    wb_rst_ni = 1'b0;
    gic_cs_i  = 1'b0;
    gic_dat_i = 4'hF;
    irq_i     = 32'h0;
    m_ack = 2'b00; m_dat = 32'h0; m_has = 1'b0;

    // Reset values
    repeat (3) @(negedge wb_clk_i);
    check_reset_outputs("reset");
    chk("reset cti_bte", {27'h0, wbm_cti_o, wbm_bte_o}, 32'h0);
    wb_rst_ni = 1'b1;
    repeat (2) @(negedge wb_clk_i);

    // Read returning DEADBEEF, then replay it with an RTY command
    wb_mode = 0; wb_lat = 2; wb_rdata = 32'hDEADBEEF;
    run_frame("read_deadbeef", 4'b0000, 4'hF, 32'h00000010, 32'h0, 4'h0);
    wb_rdata = 32'h12345678;
    run_frame("rty_replay", 4'b0010, 4'h0, 32'h0, 32'h0, 4'h0);

    // Write, then a read with a corrupted checksum
    wb_lat = 0;
    run_frame("write", 4'b1000, 4'b0001, 32'h00000004, 32'h00000001, 4'h0);
    run_frame("bad_cks", 4'b0000, 4'hF, 32'h00000010, 32'h0, 4'b0001);

    // Silent slave: timeout reported as ERR
    wb_mode = 3;
    run_frame("timeout", 4'b0000, 4'hF, 32'h00000040, 32'h0, 4'h0);

    // Response priority and plain err/rty
    wb_rdata = 32'hCAFEF00D; wb_lat = 1;
    wb_mode = 4; run_frame("prio_ack", 4'b0000, 4'h3, 32'h00000100, 32'h0, 4'h0);
    wb_mode = 5; run_frame("prio_err", 4'b0000, 4'hC, 32'h00000104, 32'h0, 4'h0);
    wb_mode = 2; run_frame("rty_resp", 4'b1001, 4'h5, 32'h00000108, 32'hA5A5A5A5, 4'h0);

    // IRQ query
    irq_i = 32'h80000421;
    run_frame("irq", 4'b0100, 4'hF, 32'h0, 32'h0, 4'h0);

    // Reset in the middle of the address field
    send_nib(4'b1010); send_nib(4'b0000); send_nib(4'hF);
    send_nib(4'h1); send_nib(4'h2); send_nib(4'h3);
    @(negedge wb_clk_i);
    gic_cs_i = 1'b1;
    #2 wb_rst_ni = 1'b0;
    #1 check_reset_outputs("rst_rx_adr");
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1; gic_cs_i = 1'b0; gic_dat_i = 4'hF;
    m_ack = 2'b00; m_dat = 32'h0; m_has = 1'b0;
    run_frame("replay_after_rst", 4'b0010, 4'h0, 32'h0, 32'h0, 4'h0);
    wb_mode = 0; wb_lat = 3; wb_rdata = 32'h0BADF00D;
    run_frame("read_after_rst", 4'b0000, 4'hF, 32'h00000010, 32'h0, 4'h0);

    // Reset while a Wishbone cycle is open
    wb_mode = 3;
    send_req(4'b0000, 4'hF, 32'h00000020, 32'h0, rx_cks(4'hF, 32'h00000020, 32'h0, 1'b0));
    repeat (5) @(negedge wb_clk_i);
    chk("rst_wb cyc_open", {31'h0, wbm_cyc_o}, 32'h1);
    #2 wb_rst_ni = 1'b0;
    #1 chk("rst_wb cyc_drop", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    m_ack = 2'b00; m_dat = 32'h0; m_has = 1'b0;
    wb_mode = 0; wb_lat = 0; wb_rdata = 32'h600DCAFE;
    run_frame("read_after_wb_rst", 4'b0000, 4'h6, 32'h00000024, 32'h0, 4'h0);

    // Randomised transactions
    for (int k = 0; k < 24; k++) begin
      logic       w, irq, rty;
      logic [3:0] flip;
      w   = 1'($urandom_range(0, 1));
      rty = ($urandom_range(0, 5) == 0);
      irq = !w && ($urandom_range(0, 4) == 0);
      wb_mode = $urandom_range(0, 5);
      if (wb_mode == 3) wb_mode = 0;
      wb_lat   = $urandom_range(0, 4);
      wb_rdata = $urandom();
      irq_i    = $urandom();
      flip = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_frame("rand", {w, irq, rty, 1'($urandom_range(0, 1))}, 4'($urandom_range(0, 15)),
                $urandom(), $urandom(), flip);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
